// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader.
// The FSM state enum is shared so checkers can decode the loader's r_state.
package fwrisc_uart_loader_pkg;

    typedef enum logic [1:0] {
        S_WAIT_FIRST,
        S_RECV,
        S_FLUSH,
        S_DONE
    } loader_state_e;

    localparam int BYTES_PER_WORD         = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_program_loader_timer.sv
// Loadable down-counter that parks at zero.
// Serves as both the idle-timeout counter and the acknowledge-length counter.
module uart_loader_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/uart_program_loader.sv
// Packs UART bytes little-endian into instruction-memory words and holds the core in reset until done.
// Optional running byte checksum on prog_sum when UART_LOADER_CHECKSUM_EN is defined.
module uart_program_loader
    import fwrisc_uart_loader_pkg::*;
#(
    parameter  int MEM_BYTES      = 4096,
    localparam int ADDR_W         = $clog2(MEM_BYTES / BYTES_PER_WORD),
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter  int ACK_LEN        = 4,
    localparam int BC_W           = $clog2(MEM_BYTES) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              program_receiving,
    output logic              program_done,
    output logic              program_ov,
    output logic              core_hold,
    output logic [BC_W-1:0]   byte_count,
    output logic [7:0]        prog_sum
);

    localparam int IDLE_W = cnt_width(TIMEOUT_CYCLES);
    localparam int ACK_W  = cnt_width(ACK_LEN);

    loader_state_e     r_state;
    loader_state_e     w_next_state;
    logic [BC_W-1:0]   r_byte_count;
    logic [31:0]       r_word;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_ov;
    logic              w_accept;
    logic              w_drop;
    logic              w_in_recv;
    logic              w_timeout;
    logic              w_full;
    logic [1:0]        w_lane;
    logic [IDLE_W-1:0] w_idle_count;
    logic [ACK_W-1:0]  w_ack_count;

    assign w_lane    = r_byte_count[1:0];
    assign w_full    = (r_byte_count == BC_W'(MEM_BYTES - 1));
    assign w_timeout = w_in_recv && !rx_valid && (w_idle_count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_WAIT_FIRST;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT_FIRST: if (rx_valid) w_next_state = w_full ? S_DONE : S_RECV;
            S_RECV: begin
                if (w_accept && w_full) begin
                    w_next_state = S_DONE;
                end else if (w_timeout) begin
                    w_next_state = (w_lane != 2'd0) ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_DONE;
        endcase
    end

    always_comb begin
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_in_recv    = 1'b0;
        program_done = 1'b0;
        core_hold    = 1'b1;
        case (r_state)
            S_WAIT_FIRST: w_accept = rx_valid;
            S_RECV: begin
                w_accept  = rx_valid;
                w_in_recv = 1'b1;
            end
            S_FLUSH: w_drop = rx_valid;
            S_DONE: begin
                w_drop       = rx_valid;
                program_done = 1'b1;
                core_hold    = 1'b0;
            end
        endcase
    end

    // A completed word is registered here, so its write strobe trails the lane-3 byte by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte_count <= '0;
            r_word       <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_ov         <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_drop) begin
                r_ov <= 1'b1;
            end
            if (w_accept) begin
                r_byte_count <= r_byte_count + BC_W'(1);
                if (w_lane == 2'd3) begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_byte_count[ADDR_W+1:2];
                    r_mem_wdata <= {rx_data, r_word[23:0]};
                    r_word      <= '0;
                end else begin
                    r_word[{w_lane, 3'b000} +: 8] <= rx_data;
                end
            end else if (w_timeout && (w_lane != 2'd0)) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_byte_count[ADDR_W+1:2];
                r_mem_wdata <= r_word;
                r_word      <= '0;
            end
        end
    end

    uart_loader_timer #(.W(IDLE_W)) u_idle_timer (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (IDLE_W'(TIMEOUT_CYCLES - 1)),
        .i_dec      (w_in_recv),
        .o_count    (w_idle_count)
    );

    uart_loader_timer #(.W(ACK_W)) u_ack_timer (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (ACK_W'(ACK_LEN)),
        .i_dec      (1'b1),
        .o_count    (w_ack_count)
    );

    assign program_receiving = (w_ack_count != '0);
    assign mem_we            = r_mem_we;
    assign mem_addr          = r_mem_addr;
    assign mem_wdata         = r_mem_wdata;
    assign program_ov        = r_ov;
    assign byte_count        = r_byte_count;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sum <= 8'h00;
        end else if (w_accept) begin
            r_sum <= r_sum + rx_data;
        end
    end

    assign prog_sum = r_sum;
`else
    assign prog_sum = 8'h00;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed + randomized bench for uart_program_loader; expected writes come from a byte-queue model.
// Honours UART_LOADER_CHECKSUM_EN for the prog_sum expectation.
module tb_uart_program_loader;

    localparam int MEM_BYTES = 4096;
    localparam int ADDR_W    = 10;
    localparam int TIMEOUT   = 600;
    localparam int ACK_LEN   = 4;
    localparam int BC_W      = 13;
    localparam int WR_W      = ADDR_W + 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              program_receiving;
    logic              program_done;
    logic              program_ov;
    logic              core_hold;
    logic [BC_W-1:0]   byte_count;
    logic [7:0]        prog_sum;

    uart_program_loader #(
        .MEM_BYTES      (MEM_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ACK_LEN        (ACK_LEN)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .program_receiving (program_receiving),
        .program_done      (program_done),
        .program_ov        (program_ov),
        .core_hold         (core_hold),
        .byte_count        (byte_count),
        .prog_sum          (prog_sum)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Observed write stream and whether program_done rose with each write.
    logic [WR_W-1:0] got_q[$];
    logic [WR_W-1:0] exp_q[$];
    bit              we_rise_q[$];
    logic            prev_done = 1'b0;

    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            got_q.push_back({mem_addr, mem_wdata});
            we_rise_q.push_back(program_done === 1'b1 && prev_done !== 1'b1);
        end
        prev_done = program_done;
    end

    // Reference model: the bytes accepted since reset, their sum, and whether loading has ended.
    logic [7:0] sent_q[$];
    logic [7:0] m_sum;
    bit         m_done;
    int         acc_cyc;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        got_q.delete();
        we_rise_q.delete();
        exp_q.delete();
        sent_q.delete();
        m_sum  = 8'h00;
        m_done = 1'b0;
    endtask

    task automatic check_sum(input string tag);
`ifdef UART_LOADER_CHECKSUM_EN
        chk({tag, "_prog_sum"}, prog_sum, m_sum);
`else
        chk({tag, "_prog_sum"}, prog_sum, 8'h00);
`endif
    endtask

    // Host side: send one byte, then require a fresh ACK_LEN-cycle acknowledge before moving on.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ack_ok;
        chk("ack_low_before_send", program_receiving, 1'b0);
        @(posedge clock); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        acc_cyc  = cyc;
        sent_q.push_back(b);
        m_sum = m_sum + b;
        if (sent_q.size() == MEM_BYTES) m_done = 1'b1;
        ack_ok = 1'b1;
        for (int i = 0; i < ACK_LEN; i++) begin
            if (i > 0) begin
                @(posedge clock); #1;
            end
            if (program_receiving !== 1'b1) ack_ok = 1'b0;
        end
        @(posedge clock); #1;
        if (program_receiving !== 1'b0) ack_ok = 1'b0;
        chk("ack_pulse_len", ack_ok, 1'b1);
        repeat (gap) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic send_drop(input logic [7:0] b);
        bit quiet;
        quiet = 1'b1;
        @(posedge clock); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
        for (int i = 0; i < ACK_LEN + 2; i++) begin
            if (program_receiving !== 1'b0 || mem_we !== 1'b0) quiet = 1'b0;
            @(posedge clock); #1;
        end
        chk("ovf_no_ack_no_write", quiet, 1'b1);
    endtask

    task automatic build_exp(input bit flush);
        exp_q.delete();
        for (int w = 0; w < sent_q.size() / 4; w++) begin
            exp_q.push_back({ADDR_W'(w), sent_q[4*w+3], sent_q[4*w+2], sent_q[4*w+1], sent_q[4*w]});
        end
        if (flush && (sent_q.size() % 4 != 0)) begin
            logic [31:0] pw;
            int          base;
            pw   = 32'h0;
            base = (sent_q.size() / 4) * 4;
            for (int j = 0; base + j < sent_q.size(); j++) pw[8*j +: 8] = sent_q[base+j];
            exp_q.push_back({ADDR_W'(sent_q.size() / 4), pw});
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_write_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_write"}, got_q[i], exp_q[i]);
        end
    endtask

    task automatic wait_done(input bit flush, input string tag);
        bit seen;
        bit hold_ok;
        int k;
        seen    = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < TIMEOUT + 50 && !seen; i++) begin
            @(posedge clock); #1;
            if (program_done === 1'b1) seen = 1'b1;
            else if (core_hold !== 1'b1) hold_ok = 1'b0;
        end
        k = cyc - acc_cyc;
        chk({tag, "_done_seen"}, seen, 1'b1);
        chk({tag, "_hold_until_done"}, hold_ok, 1'b1);
        n_tests++;
        assert (k >= TIMEOUT && k <= TIMEOUT + 1) else begin
            n_fail++;
            $error("FAIL %s_timeout_latency: observed %0d cycles expected %0d..%0d", tag, k, TIMEOUT, TIMEOUT + 1);
        end
        m_done = 1'b1;
        build_exp(flush);
        repeat (2) begin
            @(posedge clock); #1;
        end
        chk({tag, "_done_sticky"}, program_done, 1'b1);
        chk({tag, "_core_released"}, core_hold, 1'b0);
        chk({tag, "_byte_count"}, byte_count, sent_q.size());
        check_writes(tag);
        check_sum(tag);
    endtask

    initial begin
        int n;

        // Reset state
        do_reset();
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_receiving", program_receiving, 1'b0);
        chk("rst_done", program_done, 1'b0);
        chk("rst_ov", program_ov, 1'b0);
        chk("rst_core_hold", core_hold, 1'b1);
        chk("rst_byte_count", byte_count, '0);
        chk("rst_prog_sum", prog_sum, 8'h00);
        repeat (TIMEOUT + 20) @(posedge clock);
        #1;
        chk("wait_first_no_timeout", program_done, 1'b0);

        // Eight bytes with random spacing: two whole words, no flush at timeout
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), (i == 8) ? 0 : $urandom_range(0, 400));
            chk("A_hold_while_loading", core_hold, 1'b1);
        end
        build_exp(1'b0);
        chk("A_word0", got_q[0], {10'd0, 32'h04030201});
        chk("A_word1", got_q[1], {10'd1, 32'h08070605});
        chk("A_byte_count", byte_count, 13'd8);
        wait_done(1'b0, "A");

        // Six bytes then idle: partial word flushed with zero upper lanes
        do_reset();
        send_byte(8'hAA, 3);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 17);
        send_byte(8'hDD, 5);
        send_byte(8'hEE, 0);
        send_byte(8'hFF, 0);
        wait_done(1'b1, "B");
        chk("B_flush_word", got_q[1], {10'd1, 32'h0000FFEE});

        // Random lengths and contents
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) send_byte(8'($urandom), (i == n - 1) ? 0 : $urandom_range(0, 100));
            wait_done(1'b1, "R");
        end

        // Fill the whole memory; completion coincides with the last write
        do_reset();
        for (int i = 0; i < MEM_BYTES; i++) send_byte(8'(i), 0);
        build_exp(1'b0);
        check_writes("C");
        chk("C_last_word", got_q[MEM_BYTES/4-1], {10'd1023, 32'hFFFEFDFC});
        chk("C_done_with_last_we", we_rise_q[we_rise_q.size()-1], 1'b1);
        chk("C_done", program_done, 1'b1);
        chk("C_core_released", core_hold, 1'b0);
        chk("C_byte_count", byte_count, 13'd4096);
        chk("C_ov_clear", program_ov, 1'b0);
        check_sum("C");

        // Byte after completion is dropped
        got_q.delete();
        send_drop(8'hBA);
        chk("ovf_flag", program_ov, 1'b1);
        chk("ovf_no_write", got_q.size(), 0);
        chk("ovf_byte_count", byte_count, 13'd4096);
        check_sum("ovf");

        // Reset clears sticky flags and outputs
        do_reset();
        chk("rst2_ov", program_ov, 1'b0);
        chk("rst2_done", program_done, 1'b0);
        chk("rst2_core_hold", core_hold, 1'b1);
        chk("rst2_mem_addr", mem_addr, '0);
        chk("rst2_mem_wdata", mem_wdata, 32'h0);

        // Reset mid-download discards the partial word
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), $urandom_range(0, 20));
        do_reset();
        chk("mid_rst_byte_count", byte_count, '0);
        chk("mid_rst_core_hold", core_hold, 1'b1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        build_exp(1'b0);
        check_writes("D");
        chk("D_word0", got_q[0], {10'd0, 32'h44332211});
        chk("D_ov", program_ov, 1'b0);
        chk("D_byte_count", byte_count, 13'd4);
        check_sum("D");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Receive-side endpoint of the UART program-download path inside the FPGA top.
- Consumes the byte stream delivered by the UART RX core.
- Packs bytes little-endian into 32-bit words and writes them to instruction memory.
- Paces the host with a per-byte acknowledge.
- Holds the fwrisc core in reset until the download completes by byte count or idle timeout.

Parameters:
MEM_BYTES, 4096, program memory size in bytes; must be a multiple of 4.
ADDR_W, $clog2(MEM_BYTES/4), word-address width (derived, not overridden).
TIMEOUT_CYCLES, 200000, idle clock cycles after the last byte that end a short download.
ACK_LEN, 4, cycles program_receiving stays high per accepted byte.

Ports:
clock  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte from UART RX core
rx_valid  input  1  one-cycle strobe; rx_data valid
mem_we  output  1  instruction-memory word write strobe
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  word data; byte n of the stream goes to bits [8n+7:8n] of its word
program_receiving  output  1  per-byte acknowledge pulse to host
program_done  output  1  download complete (sticky)
program_ov  output  1  byte received after completion (sticky)
core_hold  output  1  holds CPU in reset while loading
byte_count  output  $clog2(MEM_BYTES)+1  bytes accepted so far
prog_sum  output  8  running checksum (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0, except core_hold=1.
  - State S_WAIT_FIRST; shift word, lane index, idle and ack counters cleared.
  - Memory contents untouched.
- Reset asserted mid-download aborts immediately. The partial word is discarded; core_hold returns to 1.
- States:
  - S_WAIT_FIRST: no timeout. rx_valid accepts the byte and moves to S_RECV.
  - S_RECV: each rx_valid accepts a byte and clears the idle counter. Otherwise the idle counter increments.
    - Idle counter reaching TIMEOUT_CYCLES-1 with lane!=0 -> S_FLUSH.
    - Idle counter reaching TIMEOUT_CYCLES-1 with lane==0 -> S_DONE.
  - S_FLUSH: exactly one cycle. Writes the partial word with unfilled lanes zero, at address byte_count>>2. Then -> S_DONE.
  - S_DONE: program_done=1 and core_hold=0, until reset.
- Byte accept:
  - Byte goes into lane byte_count[1:0]; byte_count increments.
  - When the lane-3 byte is accepted, mem_we pulses for 1 cycle in the next cycle (latency 1). mem_addr = (byte_count_before)>>2; mem_wdata = assembled word.
  - mem_addr and mem_wdata are valid only while mem_we=1 and hold their last values otherwise.
- Full: when the accepted byte makes byte_count==MEM_BYTES, the final word is written and the FSM goes directly to S_DONE. program_done rises in the same cycle as that mem_we.
- Acknowledge:
  - program_receiving rises the cycle after each accepted byte and stays high ACK_LEN cycles.
  - A byte accepted while ack is high reloads the counter, so no new rising edge is produced. The host must wait for a rising edge before sending the next byte.
- Overflow: rx_valid in S_FLUSH or S_DONE drops the byte. It sets program_ov (sticky), produces no ack and no write, and leaves byte_count unchanged.
- byte_count saturates at MEM_BYTES by construction.
- The idle counter is wide enough for TIMEOUT_CYCLES and does not wrap.

Optional Feature:
Macro: UART_LOADER_CHECKSUM_EN.
- Defined: prog_sum is the modulo-256 sum of all accepted bytes. It updates the cycle after accept, clears on reset, and ignores dropped (overflow) bytes.
- Undefined: prog_sum is tied to 8'h00; the accumulator logic is absent; the port list is unchanged.

Decomposition:
- Package fwrisc_uart_loader_pkg holds:
  - state enum loader_state_e {S_WAIT_FIRST, S_RECV, S_FLUSH, S_DONE};
  - constant BYTES_PER_WORD=4;
  - localparam helper for the default timeout.
- One sub-module, uart_loader_timer: the loadable idle/ack down-counter, instantiated twice (timeout, ack length).

Test Plan:
- Send 8 bytes 01..08 spaced 2000 cycles -> writes addr0=32'h04030201, addr1=32'h08070605; byte_count=8; core_hold stays 1 until timeout, then program_done=1 with no extra write.
- Send 6 bytes AA,BB,CC,DD,EE,FF then idle -> after TIMEOUT_CYCLES one flush write addr1=32'h0000FFEE; program_done=1, core_hold=0.
- Send 4096 bytes (byte i = i[7:0]) -> 1024 writes, last addr 1023 = 32'hFFFEFDFC; program_done in the same cycle as the final mem_we; prog_sum=8'h00 (with _EN).
- After done, send 8'hBA -> program_ov=1, no mem_we, no program_receiving edge, byte_count=4096.
- Assert reset after 3 bytes, then send 4 bytes 11,22,33,44 -> first write addr0=32'h44332211; program_ov=0.
- Each accepted byte -> program_receiving high exactly ACK_LEN=4 cycles starting 1 cycle after rx_valid.
